// File: rtl/fpu_issue_if.sv
// Command/response handshake bundle between a requester and fpu_issue_ctrl.
// The FP operand width follows STD, which must match the controller's STD.
interface fpu_issue_if #(
    parameter int STD = 15
);
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_op;
    logic         req_uns;
    logic [2:0]   req_frm;
    logic [STD:0] req_a;
    logic [STD:0] req_b;
    logic [STD:0] req_c;
    logic [31:0]  req_int;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [STD:0] rsp_fp;
    logic [31:0]  rsp_int;
    logic [4:0]   rsp_flags;

    modport master (
        output req_valid, req_op, req_uns, req_frm, req_a, req_b, req_c, req_int, rsp_ready,
        input  req_ready, rsp_valid, rsp_fp, rsp_int, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_uns, req_frm, req_a, req_b, req_c, req_int, rsp_ready,
        output req_ready, rsp_valid, rsp_fp, rsp_int, rsp_flags
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller for a fixed-latency FPU: accepts a command,
// pulses the one-hot op for one cycle, waits LAT cycles, captures and holds the result.
module fpu_issue_ctrl #(
    parameter int STD = 15,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    fpu_issue_if.slave   bus,

    output logic [STD:0] Operand_A_w,
    output logic [STD:0] Operand_B_w,
    output logic [STD:0] Operand_C_w,
    output logic [2:0]   frm_w,
    output logic [23:0]  sfpu_op_w,
    output logic [27:0]  vfpu_op_w,
    output logic [2:0]   fpu_sel_w,
    output logic [31:0]  Operand_Int_w,

    input  logic [STD:0] FPU_resultant,
    input  logic [31:0]  FPU_Result_rd,
    input  logic [4:0]   S_Flags,
    input  logic         Exception_flag,

    output logic [4:0]   fflags,
    input  logic         fflags_clr,
    output logic         busy
);

    localparam int       CW            = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
    localparam logic [4:0] LAST_OP     = 5'd21;
    localparam logic [4:0] ILLEGAL_FL  = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          exc_q;
    logic          exc_unused;

    // The sampled exception is kept for observability only; reported flags come from S_Flags.
    assign exc_unused = exc_q;

    // Conversion ops 14/15 carry an extra signedness bit: 22 for unsigned, 23 for signed.
    function automatic logic [23:0] decode_op(input logic [4:0] op, input logic uns);
        logic [23:0] v;
        v = 24'(1) << op;
        if (op == 5'd14 || op == 5'd15) begin
            v[uns ? 22 : 23] = 1'b1;
        end
        return v;
    endfunction

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE);
    assign vfpu_op_w     = '0;
    assign fpu_sel_w     = '0;

    // NOTE: all state here uses non-blocking assignments; a later assignment to the same
    // register in this block (fflags on capture) deliberately overrides an earlier one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            exc_q         <= 1'b0;
            Operand_A_w   <= '0;
            Operand_B_w   <= '0;
            Operand_C_w   <= '0;
            frm_w         <= '0;
            sfpu_op_w     <= '0;
            Operand_Int_w <= '0;
            bus.rsp_fp    <= '0;
            bus.rsp_int   <= '0;
            bus.rsp_flags <= '0;
            fflags        <= '0;
        end else begin
            if (fflags_clr) begin
                fflags <= '0;
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        Operand_A_w   <= bus.req_a;
                        Operand_B_w   <= bus.req_b;
                        Operand_C_w   <= bus.req_c;
                        frm_w         <= bus.req_frm;
                        Operand_Int_w <= bus.req_int;
                        if (bus.req_op <= LAST_OP) begin
                            sfpu_op_w <= decode_op(bus.req_op, bus.req_uns);
                            state     <= ISSUE;
                        end else begin
                            // Illegal op: answer immediately with an invalid-operation flag.
                            bus.rsp_fp    <= '0;
                            bus.rsp_int   <= '0;
                            bus.rsp_flags <= ILLEGAL_FL;
                            fflags        <= fflags_clr ? ILLEGAL_FL : (fflags | ILLEGAL_FL);
                            state         <= RESP;
                        end
                    end
                end

                ISSUE: begin
                    sfpu_op_w <= '0;
                    cnt       <= CNT_LOAD;
                    state     <= WAIT;
                end

                WAIT: begin
                    if (cnt == CNT_LOAD) begin
                        exc_q <= Exception_flag;
                    end
                    if (cnt == '0) begin
                        bus.rsp_fp    <= FPU_resultant;
                        bus.rsp_int   <= FPU_Result_rd;
                        bus.rsp_flags <= S_Flags;
                        fflags        <= fflags_clr ? S_Flags : (fflags | S_Flags);
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl with a queue-driven FPU stub
// and a transaction-level model of latency, one-hot decode and sticky flags.
module tb_fpu_issue_ctrl;

    localparam int STD = 15;
    localparam int LAT = 2;
    localparam int W   = STD + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [STD:0] Operand_A_w, Operand_B_w, Operand_C_w;
    logic [2:0]   frm_w;
    logic [23:0]  sfpu_op_w;
    logic [27:0]  vfpu_op_w;
    logic [2:0]   fpu_sel_w;
    logic [31:0]  Operand_Int_w;
    logic [STD:0] FPU_resultant;
    logic [31:0]  FPU_Result_rd;
    logic [4:0]   S_Flags;
    logic         Exception_flag;
    logic [4:0]   fflags;
    logic         fflags_clr;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] fflags_m = '0;

    fpu_issue_if #(.STD(STD)) bus ();

    fpu_issue_ctrl #(.STD(STD), .LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .Operand_A_w    (Operand_A_w),
        .Operand_B_w    (Operand_B_w),
        .Operand_C_w    (Operand_C_w),
        .frm_w          (frm_w),
        .sfpu_op_w      (sfpu_op_w),
        .vfpu_op_w      (vfpu_op_w),
        .fpu_sel_w      (fpu_sel_w),
        .Operand_Int_w  (Operand_Int_w),
        .FPU_resultant  (FPU_resultant),
        .FPU_Result_rd  (FPU_Result_rd),
        .S_Flags        (S_Flags),
        .Exception_flag (Exception_flag),
        .fflags         (fflags),
        .fflags_clr     (fflags_clr),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // FPU stub: an issued op's result is registered LAT edges later and shows junk otherwise.
    typedef struct packed {
        logic         v;
        logic [STD:0] fp;
        logic [31:0]  i;
        logic [4:0]   fl;
    } res_t;

    res_t exp_q[$];
    res_t pipe[LAT];

    initial begin
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        if (sfpu_op_w != '0 && exp_q.size() > 0) pipe[0] <= exp_q.pop_front();
        else pipe[0] <= '0;
    end

    assign FPU_resultant  = pipe[LAT-1].v ? pipe[LAT-1].fp : W'(16'hA5C3);
    assign FPU_Result_rd  = pipe[LAT-1].v ? pipe[LAT-1].i  : 32'hDEAD_BEEF;
    assign S_Flags        = pipe[LAT-1].v ? pipe[LAT-1].fl : 5'b11111;
    assign Exception_flag = pipe[0].v && (pipe[0].fl != '0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction, starting and ending just after a falling edge with the block idle.
    task automatic send(input logic [4:0] op, input logic uns, input logic [2:0] frm,
                        input logic [STD:0] a, input logic [STD:0] b, input logic [STD:0] c,
                        input logic [31:0] iv, input logic [STD:0] r_fp, input logic [31:0] r_int,
                        input logic [4:0] r_fl, input logic clr, input int hold, input logic poke);
        logic        legal;
        logic [23:0] exp_oh;
        logic [4:0]  exp_fl;
        logic [23:0] seen;
        int          nz, edges, n;

        legal  = (op <= 5'd21);
        exp_oh = '0;
        if (legal) begin
            exp_oh[op] = 1'b1;
            if (op == 5'd14 || op == 5'd15) exp_oh[uns ? 22 : 23] = 1'b1;
            exp_q.push_back('{v: 1'b1, fp: r_fp, i: r_int, fl: r_fl});
        end
        exp_fl = legal ? r_fl : 5'b10000;

        bus.req_valid = 1'b1; bus.req_op = op; bus.req_uns = uns; bus.req_frm = frm;
        bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_int = iv;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        fflags_clr = clr && !legal;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        fflags_clr    = 1'b0;

        edges = 0; nz = 0; seen = '0;
        while (!bus.rsp_valid && edges < 20) begin
            if (sfpu_op_w != '0) begin
                nz++;
                seen = sfpu_op_w;
                check("opnd_a", 64'(Operand_A_w), 64'(a));
                check("opnd_c", 64'(Operand_C_w), 64'(c));
                check("opnd_frm", 64'(frm_w), 64'(frm));
                check("opnd_int", 64'(Operand_Int_w), 64'(iv));
            end
            fflags_clr = clr && legal && (edges == LAT);
            @(posedge clk);
            @(negedge clk);
            fflags_clr = 1'b0;
            edges++;
        end

        fflags_m = clr ? exp_fl : (fflags_m | exp_fl);
        check("latency", 64'(edges), legal ? 64'(LAT + 1) : 64'd0);
        check("sfpu_cycles", 64'(nz), legal ? 64'd1 : 64'd0);
        if (legal) check("sfpu_onehot", 64'(seen), 64'(exp_oh));
        check("vfpu_sel_zero", 64'({vfpu_op_w, fpu_sel_w}), 64'd0);
        check("rsp_fp", 64'(bus.rsp_fp), legal ? 64'(r_fp) : 64'd0);
        check("rsp_int", 64'(bus.rsp_int), legal ? 64'(r_int) : 64'd0);
        check("rsp_flags", 64'(bus.rsp_flags), 64'(exp_fl));
        check("fflags", 64'(fflags), 64'(fflags_m));
        check("resp_ready_low", 64'(bus.req_ready), 64'd0);

        if (poke) begin
            bus.req_valid = 1'b1; bus.req_op = 5'd30;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_data", 64'({bus.rsp_fp, bus.rsp_int, bus.rsp_flags}),
                  legal ? 64'({r_fp, r_int, exp_fl}) : 64'({W'(0), 32'd0, exp_fl}));
            if (poke) check("hold_no_accept", 64'({bus.req_ready, busy}), 64'b01);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("back_idle", 64'({busy, bus.rsp_valid, bus.req_ready}), 64'b001);

        if (poke) begin
            // The request held during RESP is taken on the very next edge.
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
            fflags_m = fflags_m | 5'b10000;
            check("poke_accepted", 64'({bus.rsp_valid, bus.rsp_flags}), 64'({1'b1, 5'b10000}));
            check("poke_fflags", 64'(fflags), 64'(fflags_m));
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [4:0] op;
        int         nrv;

        rst = 1'b1; fflags_clr = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_uns = 1'b0; bus.req_frm = '0;
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_int = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 64'({busy, bus.rsp_valid, bus.req_ready, fflags}), 64'd0);
        check("rst_datapath", 64'({Operand_A_w, sfpu_op_w, bus.rsp_fp}), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'({bus.req_ready, bus.rsp_valid, busy}), 64'b100);

        // Fadd 1.0 + 1.0
        send(5'd0, 1'b0, 3'd0, 16'h3C00, 16'h3C00, 16'h0000, 32'd0, 16'h4000, 32'd0, 5'd0, 1'b0, 0, 1'b0);
        // Fcvt.w of -5.0, signed
        send(5'd14, 1'b0, 3'd1, 16'hC500, 16'h0000, 16'h0000, 32'd0, 16'h0000, 32'hFFFF_FFFB, 5'd0, 1'b0, 1, 1'b0);
        // Fcvt.wu, unsigned variant
        send(5'd15, 1'b1, 3'd2, 16'h4500, 16'h0000, 16'h0000, 32'd0, 16'h0000, 32'd5, 5'd0, 1'b0, 0, 1'b0);
        // Illegal op
        send(5'd25, 1'b0, 3'd0, 16'h1234, 16'h0000, 16'h0000, 32'd7, 16'h0000, 32'd0, 5'd0, 1'b0, 0, 1'b0);
        check("illegal_fflags", 64'(fflags), 64'(5'b10000));
        // Response held for 5 cycles with a competing request pending
        send(5'd3, 1'b0, 3'd0, 16'h3800, 16'h4000, 16'h0000, 32'd0, 16'h3A00, 32'd0, 5'b00001, 1'b0, 5, 1'b1);

        // fflags_clr alone
        fflags_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fflags_clr = 1'b0;
        fflags_m = '0;
        check("clr_alone", 64'(fflags), 64'd0);

        // Clear coincident with capture vs plain accumulate
        send(5'd1, 1'b0, 3'd0, 16'h1111, 16'h2222, 16'h0, 32'd0, 16'h0101, 32'd0, 5'b01000, 1'b1, 0, 1'b0);
        send(5'd2, 1'b0, 3'd0, 16'h3333, 16'h4444, 16'h0, 32'd0, 16'h0202, 32'd0, 5'b00001, 1'b1, 0, 1'b0);
        check("clr_at_capture", 64'(fflags), 64'(5'b00001));
        send(5'd1, 1'b0, 3'd0, 16'h5555, 16'h6666, 16'h0, 32'd0, 16'h0303, 32'd0, 5'b01000, 1'b1, 0, 1'b0);
        send(5'd2, 1'b0, 3'd0, 16'h7777, 16'h8888, 16'h0, 32'd0, 16'h0404, 32'd0, 5'b00001, 1'b0, 0, 1'b0);
        check("accumulate", 64'(fflags), 64'(5'b01001));

        // Reset during the first WAIT cycle aborts with no response
        exp_q.push_back('{v: 1'b1, fp: 16'h7E00, i: 32'd9, fl: 5'b00100});
        bus.req_valid = 1'b1; bus.req_op = 5'd4;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fflags_m = '0;
        check("abort_state", 64'({busy, bus.rsp_valid, fflags, bus.rsp_flags}), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_ready", 64'(bus.req_ready), 64'd1);
        nrv = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rsp_valid || busy) nrv++;
        end
        check("abort_no_rsp", 64'(nrv), 64'd0);
        check("abort_fflags", 64'(fflags), 64'd0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
            send(op, 1'($urandom), 3'($urandom), W'($urandom), W'($urandom), W'($urandom), $urandom,
                 W'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter STD, default 15, sets the FP operand MSB index; operands are STD+1 bits wide.
REQ-002 Parameter LAT, default 2, is the FPU pipeline depth in clock edges, from operands driven to registered result.
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, synchronous active-high reset.
REQ-005 Ports req_valid (input, 1) and req_ready (output, 1) form the command handshake.
REQ-006 Port req_op, input, 5 bits, operation index 0-21 in sfpu bit order.
REQ-007 Port req_uns, input, 1 bit, selects unsigned (1) or signed (0) for conversion ops 14/15.
REQ-008 Port req_frm, input, 3 bits, rounding mode.
REQ-009 Ports req_a, req_b, req_c, input, STD+1 bits each, FP operands.
REQ-010 Port req_int, input, 32 bits, integer operand.
REQ-011 Ports Operand_A_w, Operand_B_w, Operand_C_w, frm_w, sfpu_op_w[23:0], vfpu_op_w[27:0], fpu_sel_w[2:0], Operand_Int_w[31:0], outputs, drive the FPU.
REQ-012 Ports FPU_resultant (STD+1), FPU_Result_rd (32), S_Flags (5), Exception_flag (1), inputs, carry the FPU result.
REQ-013 Ports rsp_valid (output, 1) and rsp_ready (input, 1) form the response handshake.
REQ-014 Ports rsp_fp (STD+1), rsp_int (32), rsp_flags (5), outputs, carry the captured response.
REQ-015 Port fflags, output, 5 bits, sticky accrued flags {NV,DZ,OF,UF,NX}.
REQ-016 Port fflags_clr, input, 1 bit, clears fflags.
REQ-017 Port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-018 FSM states are IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A handshake in IDLE SHALL latch all req_* fields; a legal op (0-21) SHALL go to ISSUE, and an illegal op (22-31) SHALL go to RESP with rsp_fp=0, rsp_int=0, rsp_flags=5'b10000, and no FPU issue.
REQ-020 In ISSUE (exactly one cycle), sfpu_op_w SHALL be one-hot at the latched op.
- For ops 14/15, bit 22 is also set if req_uns=1, otherwise bit 23.
- Operand/frm outputs carry latched values.
REQ-021 Outside ISSUE, sfpu_op_w SHALL be 0; vfpu_op_w and fpu_sel_w SHALL always be 0; operand outputs hold their last values.
REQ-022 WAIT SHALL last LAT cycles, counted by a down-counter.
- Exception_flag is sampled on the first WAIT edge.
- FPU_resultant, FPU_Result_rd and S_Flags are captured into rsp_* on the final WAIT edge, and the FSM then goes to RESP.
- Total latency is accept edge to rsp_valid high = LAT+1 edges (3 by default).
REQ-023 rsp_valid SHALL be 1 only in RESP, and rsp_* SHALL stay stable until rsp_valid&rsp_ready, which returns the FSM to IDLE; rsp_ready while not in RESP SHALL be ignored.
REQ-024 On each capture (including an illegal op), fflags SHALL update to fflags|rsp_flags (new value).
- fflags_clr alone sets fflags to 0.
- fflags_clr coincident with a capture sets fflags to the new rsp_flags only.
REQ-025 An exception sampled per REQ-022 SHALL be reported in rsp_flags exactly as S_Flags presents it; the block adds no flags of its own except for the illegal op.

Reset
REQ-026 While rst=1, at the edge the block SHALL go to IDLE, and all outputs, counters, latched fields, rsp_* and fflags SHALL be 0.
- Reset mid-ISSUE/WAIT/RESP aborts with no response; FPU results arriving afterwards are ignored.
REQ-027 In the first cycle after reset release, req_ready SHALL be 1, and rsp_valid and busy SHALL be 0.

Verification
REQ-028 Fadd, op 0, a=0x3C00, b=0x3C00, real FPU -> sfpu_op_w=24'h000001 for one cycle; rsp_valid 3 edges after accept; rsp_fp=0x4000, rsp_flags=0.
REQ-029 Fcvt.w, op 14, req_uns=0, a=0xC500 (-5.0) -> sfpu_op_w=24'h804000; rsp_int=32'hFFFFFFFB, rsp_flags=0.
REQ-030 Illegal op 25 -> sfpu_op_w stays 0; rsp_valid 1 edge after accept; rsp_flags=5'b10000; fflags=5'b10000.
REQ-031 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0, and a new req_valid is not accepted; accepted on the cycle after rsp_ready=1.
REQ-032 rst=1 in the first WAIT cycle -> next cycle IDLE, rsp_valid never asserts, fflags=0.
REQ-033 FPU stub returning S_Flags=5'b00001 with fflags=5'b01000 and fflags_clr=1 at the capture edge -> fflags=5'b00001; without fflags_clr -> 5'b01001.
